// File: rtl/adder_pipe_arbiter.sv
`default_nettype none
// adder_pipe_arbiter: round-robin sharing of a 4-stage, 2-bit/stage pipelined 8-bit adder among NREQ requesters.
// Optional 16-bit transfer counter output enabled by defining ADDER_ARB_ISSUE_CNT_EN.
module adder_pipe_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_cin,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout
`ifdef ADDER_ARB_ISSUE_CNT_EN
  ,
  output logic [15:0]       issue_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            xfer;
  logic [7:0]      cur_a;
  logic [7:0]      cur_b;
  logic            cur_cin;

  logic [7:0]      skew_a    [1:3];
  logic [7:0]      skew_b    [1:3];
  logic            tag_valid [1:4];
  logic [IW-1:0]   tag_idx   [1:4];

  // First valid requester at or after the pointer, scanning upward with wrap.
  always_comb begin : arb
    int  k;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    k     = 0;
    for (int j = 0; j < NREQ; j++) begin
      k = int'(ptr) + j;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req_valid[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        gidx     = IW'(k);
      end
    end
  end

  assign req_ready = rst ? '0 : grant;
  assign xfer      = !rst && (|grant);
  assign cur_a     = xfer ? req_a[8*gidx +: 8] : 8'h00;
  assign cur_b     = xfer ? req_b[8*gidx +: 8] : 8'h00;
  assign cur_cin   = xfer & req_cin[gidx];

  // Slice k of an op reaches the adder k cycles after issue.
  assign add_a   = {skew_a[3][7:6], skew_a[2][5:4], skew_a[1][3:2], cur_a[1:0]};
  assign add_b   = {skew_b[3][7:6], skew_b[2][5:4], skew_b[1][3:2], cur_b[1:0]};
  assign add_cin = cur_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int k = 1; k <= 3; k++) begin
        skew_a[k] <= 8'h00;
        skew_b[k] <= 8'h00;
      end
      for (int k = 1; k <= 4; k++) begin
        tag_valid[k] <= 1'b0;
        tag_idx[k]   <= '0;
      end
    end else begin
      if (xfer) begin
        ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      skew_a[1]    <= cur_a;
      skew_b[1]    <= cur_b;
      tag_valid[1] <= xfer;
      tag_idx[1]   <= gidx;
      for (int k = 2; k <= 3; k++) begin
        skew_a[k] <= skew_a[k-1];
        skew_b[k] <= skew_b[k-1];
      end
      for (int k = 2; k <= 4; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!rst && tag_valid[4]) rsp_valid[tag_idx[4]] = 1'b1;
  end

  assign rsp_sum  = add_sum;
  assign rsp_cout = add_cout;

`ifdef ADDER_ARB_ISSUE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       issue_cnt <= 16'h0000;
    else if (xfer) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_arbiter.sv
`default_nettype none
// tb_adder_pipe_arbiter: directed and randomized checks of the arbiter against a queue-based reference model.
module tb_adder_pipe_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic              add_cin;
  logic [7:0]        add_sum = 8'h00;
  logic              add_cout = 1'b0;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_sum;
  logic              rsp_cout;
`ifdef ADDER_ARB_ISSUE_CNT_EN
  logic [15:0]       issue_cnt;
`endif

  adder_pipe_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_ISSUE_CNT_EN
    ,
    .issue_cnt (issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pipelined adder: stage k sums slice k of its inputs one cycle after stage k-1.
  logic [7:0] p1 = 8'h00, p2 = 8'h00, p3 = 8'h00;
  logic       c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
  always @(posedge clk) begin : adder
    logic [2:0] t0, t1, t2, t3;
    t0 = {1'b0, add_a[1:0]} + {1'b0, add_b[1:0]} + {2'b0, add_cin};
    t1 = {1'b0, add_a[3:2]} + {1'b0, add_b[3:2]} + {2'b0, c1};
    t2 = {1'b0, add_a[5:4]} + {1'b0, add_b[5:4]} + {2'b0, c2};
    t3 = {1'b0, add_a[7:6]} + {1'b0, add_b[7:6]} + {2'b0, c3};
    p1 <= {6'b0, t0[1:0]};           c1 <= t0[2];
    p2 <= {4'b0, t1[1:0], p1[1:0]};  c2 <= t1[2];
    p3 <= {2'b0, t2[1:0], p2[3:0]};  c3 <= t2[2];
    add_sum  <= {t3[1:0], p3[5:0]};
    add_cout <= t3[2];
  end

  typedef struct {
    int         due;
    int         idx;
    logic [8:0] res;
  } exp_t;

  exp_t q[$];
  int   ptr_m  = 0;
  int   cnt_m  = 0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [NREQ-1:0] smp_ready;
  logic [NREQ-1:0] smp_rsp;
  logic [7:0]      smp_sum;
  logic            smp_cout;
`ifdef ADDER_ARB_ISSUE_CNT_EN
  logic [15:0]     smp_cnt;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: grant = first valid at/after pointer; result = a+b+cin returned 4 cycles after transfer.
  task automatic check_cycle();
    logic [NREQ-1:0] er, ev;
    int         g;
    exp_t       e;
    bit         have;
    logic [7:0] a, b;
    er = '0;
    g  = -1;
    if (!rst) begin
      for (int j = 0; j < NREQ; j++) begin
        int k;
        k = (ptr_m + j) % NREQ;
        if (g < 0 && req_valid[k]) begin
          g     = k;
          er[k] = 1'b1;
        end
      end
    end
    check("req_ready", 32'(req_ready), 32'(er));

    ev   = '0;
    have = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e    = q.pop_front();
      have = 1'b1;
      if (!rst) ev[e.idx] = 1'b1;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (have && !rst) check("rsp_cout_sum", 32'({rsp_cout, rsp_sum}), 32'(e.res));

    if (g >= 0) begin
      a = req_a[8*g +: 8];
      b = req_b[8*g +: 8];
      check("add_slice0", 32'({add_cin, add_b[1:0], add_a[1:0]}), 32'({req_cin[g], b[1:0], a[1:0]}));
    end else begin
      check("add_cin_idle", 32'(add_cin), 32'd0);
    end
`ifdef ADDER_ARB_ISSUE_CNT_EN
    check("issue_cnt", 32'(issue_cnt), 32'(cnt_m % 65536));
    smp_cnt = issue_cnt;
`endif

    if (rst) begin
      q.delete();
      ptr_m = 0;
      cnt_m = 0;
    end else if (g >= 0) begin
      e.due = cyc + 4;
      e.idx = g;
      e.res = 9'(a) + 9'(b) + 9'(req_cin[g]);
      q.push_back(e);
      ptr_m = (g + 1) % NREQ;
      cnt_m++;
    end

    smp_ready = req_ready;
    smp_rsp   = rsp_valid;
    smp_sum   = rsp_sum;
    smp_cout  = rsp_cout;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_valid[i]    = 1'b1;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_cin[i]      = cin;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    repeat (2) step();
    check("reset_ready", 32'(smp_ready), 32'd0);
    check("reset_rsp", 32'(smp_rsp), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single op with full carry ripple
    set_req(0, 8'hFF, 8'h01, 1'b0);
    step();
    check("single_ready", 32'(smp_ready), 32'h1);
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        check("single_rsp_valid", 32'(smp_rsp), 32'h1);
        check("single_rsp", 32'({smp_cout, smp_sum}), 32'h100);
      end else begin
        check("single_quiet", 32'(smp_rsp), 32'h0);
      end
    end

    // Back-to-back ops on one requester must not mix slices
    set_req(2, 8'h55, 8'hAA, 1'b1);
    step();
    check("skew_ready0", 32'(smp_ready), 32'h4);
    set_req(2, 8'h0F, 8'h01, 1'b0);
    step();
    check("skew_ready1", 32'(smp_ready), 32'h4);
    req_valid = '0;
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k == 4) begin
        check("skew_rsp0_valid", 32'(smp_rsp), 32'h4);
        check("skew_rsp0", 32'({smp_cout, smp_sum}), 32'h100);
      end
      if (k == 5) begin
        check("skew_rsp1_valid", 32'(smp_rsp), 32'h4);
        check("skew_rsp1", 32'({smp_cout, smp_sum}), 32'h010);
      end
    end

    // Full load from a fresh pointer
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'h10, 1'b0);
      else req_valid = '0;
      step();
      if (k < 8) check("full_grant", 32'(smp_ready), 32'(1 << (k % 4)));
      if (k >= 4) begin
        check("full_rsp_valid", 32'(smp_rsp), 32'(1 << ((k - 4) % 4)));
        check("full_rsp_sum", 32'({smp_cout, smp_sum}), 32'(8'h10 + (k - 4) % 4));
      end
    end

    // Fairness between two requesters, then a lone requester
    for (int k = 0; k < 7; k++) begin
      req_valid = '0;
      set_req(1, 8'(k), 8'h20, 1'b1);
      if (k < 4) set_req(3, 8'(k), 8'h30, 1'b0);
      step();
      if (k < 4) check("fair_alt", 32'(smp_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      else       check("fair_solo", 32'(smp_ready), 32'h2);
    end
    idle(6);

    // Reset mid-flight discards in-flight ops and restores requester 0 priority
    for (int k = 0; k < 3; k++) begin
      req_valid = '0;
      set_req(0, 8'(k + 1), 8'h01, 1'b0);
      step();
    end
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      if (k == 6) begin
        set_req(0, 8'h11, 8'h22, 1'b0);
        set_req(2, 8'h33, 8'h44, 1'b0);
      end
      step();
      check("flush_quiet", 32'(smp_rsp), 32'h0);
      if (k == 6) check("post_reset_grant", 32'(smp_ready), 32'h1);
    end
    idle(6);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = NREQ'($urandom);
      req_a     = 32'($urandom);
      req_b     = 32'($urandom);
      req_cin   = NREQ'($urandom);
      step();
    end
    rst = 1'b0;
    idle(6);

`ifdef ADDER_ARB_ISSUE_CNT_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    check("cnt_zero", 32'(smp_cnt), 32'h0);
    for (int k = 0; k < 65537; k++) begin
      req_valid = '0;
      set_req(0, 8'(k), 8'h01, 1'b0);
      step();
    end
    idle(1);
    check("cnt_wrap", 32'(smp_cnt), 32'h1);
    idle(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
